load_store_unit: RTL and testbench

//  Multi-cycle load/store unit between the CPU datapath (ALU address, rs2 data,

---
 rtl/load_store_unit.sv | 220 ++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
//   Multi-cycle load/store unit sitting between the CPU datapath and a
//   word-wide valid/ready data bus. It does lane steering for B/H/W loads and
//   stores, generates byte strobes, sign/zero-extends load data, stalls the
//   core while an access is in flight and reports bus timeouts and illegal
//   requests as errors.
//
//   Optional feature macro: LSU_MISALIGN_TRAP_EN
//     defined   : misaligned H/W accesses are trapped without a bus cycle
//     undefined : offending low address bits are ignored, misalign stays 0
//
//   Ports
//     clk, reset                       clock, synchronous active-high reset
//     req_valid/write/funct3/addr/wdata  core request (held until rsp_valid)
//     stall                            req_valid && !rsp_valid
//     rsp_valid/rdata/err, misalign    one-cycle completion response
//     bus_valid/write/addr/wdata/wstrb bus request, stable while in BUS
//     bus_ready, bus_rdata             bus completion and load data
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   S_IDLE | waiting for req_valid, request fields latched on accept
//   S_BUS  | bus_valid high, waiting for bus_ready or timeout
//   S_RESP | rsp_valid pulse with captured data / error flags

module load_store_unit #(
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        misalign,
   output logic        bus_valid,
   input  logic        bus_ready,
   output logic        bus_write,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_wstrb,
   input  logic [31:0] bus_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  lane_q, lane_d;
   logic [2:0]  funct3_q, funct3_d;
   logic        write_q, write_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic        mis_q, mis_d;

   logic [31:0] st_wdata;
   logic [3:0]  st_wstrb;
   logic        bad_op;
   logic        mis_req;
   logic [7:0]  b_sel;
   logic [15:0] h_sel;
   logic [31:0] ld_data;

   // request decode: store lane replication, strobes and error classes
   always_comb begin
      st_wdata = req_wdata;
      st_wstrb = 4'b1111;
      case (req_funct3[1:0])
         2'b00: begin
            st_wdata = {4{req_wdata[7:0]}};
            st_wstrb = 4'b0001 << req_addr[1:0];
         end
         2'b01: begin
            st_wdata = {2{req_wdata[15:0]}};
            st_wstrb = 4'b0011 << {req_addr[1], 1'b0};
         end
         default: begin
            st_wdata = req_wdata;
            st_wstrb = 4'b1111;
         end
      endcase
      if (!req_write) st_wstrb = 4'b0000;

      // 011, 11x always illegal; unsigned variants have no store form
      bad_op = (req_funct3 == 3'b011) || (req_funct3[2] && req_funct3[1]) ||
               (req_funct3[2] && req_write);

`ifdef LSU_MISALIGN_TRAP_EN
      mis_req = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
`else
      mis_req = 1'b0;
`endif
   end

   // load data extraction from the bus word
   always_comb begin
      b_sel = bus_rdata[{lane_q, 3'b000} +: 8];
      h_sel = bus_rdata[{lane_q[1], 4'b0000} +: 16];
      case (funct3_q)
         3'b000:  ld_data = {{24{b_sel[7]}}, b_sel};
         3'b001:  ld_data = {{16{h_sel[15]}}, h_sel};
         3'b010:  ld_data = bus_rdata;
         3'b100:  ld_data = {24'h0, b_sel};
         3'b101:  ld_data = {16'h0, h_sel};
         default: ld_data = 32'h0;
      endcase
      if (write_q) ld_data = 32'h0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         addr_q   <= '0;
         lane_q   <= '0;
         funct3_q <= '0;
         write_q  <= 1'b0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         mis_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         lane_q   <= lane_d;
         funct3_q <= funct3_d;
         write_q  <= write_d;
         wdata_q  <= wdata_d;
         wstrb_q  <= wstrb_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         mis_q    <= mis_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      lane_d   = lane_q;
      funct3_d = funct3_q;
      write_d  = write_q;
      wdata_d  = wdata_q;
      wstrb_d  = wstrb_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      mis_d    = mis_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               addr_d   = {req_addr[31:2], 2'b00};
               lane_d   = req_addr[1:0];
               funct3_d = req_funct3;
               write_d  = req_write;
               wdata_d  = st_wdata;
               wstrb_d  = st_wstrb;
               rdata_d  = '0;
               cnt_d    = '0;
               err_d    = 1'b0;
               mis_d    = 1'b0;
               if (bad_op) begin
                  err_d   = 1'b1;
                  state_d = S_RESP;
               end else if (mis_req) begin
                  err_d   = 1'b1;
                  mis_d   = 1'b1;
                  state_d = S_RESP;
               end else begin
                  state_d = S_BUS;
               end
            end
         end
         S_BUS: begin
            // ready wins over the timeout limit in the same cycle
            if (bus_ready) begin
               rdata_d = ld_data;
               state_d = S_RESP;
            end else if (cnt_q == CNT_LAST) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_RESP: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus_valid = (state_q == S_BUS);
      rsp_valid = (state_q == S_RESP);
      bus_write = bus_valid & write_q;
      bus_addr  = bus_valid ? addr_q  : 32'h0;
      bus_wdata = bus_valid ? wdata_q : 32'h0;
      bus_wstrb = bus_valid ? wstrb_q : 4'h0;
      rsp_rdata = rsp_valid ? rdata_q : 32'h0;
      rsp_err   = rsp_valid & err_q;
      misalign  = rsp_valid & mis_q;
      stall     = req_valid & ~rsp_valid;
   end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        stall;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        misalign;
   logic        bus_valid;
   logic        bus_ready;
   logic        bus_write;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_wstrb;
   logic [31:0] bus_rdata;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   load_store_unit dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_write(req_write), .req_funct3(req_funct3),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .misalign(misalign),
      .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_write(bus_write),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
      .bus_rdata(bus_rdata)
   );

   typedef struct {
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          delay;     // bus cycles with ready low before ready
      int          drop;      // cycle at which req_valid is dropped, -1 none
      int          lat;       // cycle of rsp_valid (request = cycle 0)
      logic [31:0] exp_rdata;
      logic        exp_err;
      logic        exp_mis;
      int          exp_nbus;
      logic [31:0] exp_baddr;
      logic [31:0] exp_bwdata;
      logic [3:0]  exp_wstrb;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic wr, logic [2:0] f3, logic [31:0] addr,
                               logic [31:0] wdata, logic [31:0] rdata,
                               int delay, int drop, int lat,
                               logic [31:0] exp_rdata, logic exp_err,
                               logic exp_mis, int exp_nbus,
                               logic [31:0] exp_baddr, logic [31:0] exp_bwdata,
                               logic [3:0] exp_wstrb);
      vec_t v;
      v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
      v.delay = delay; v.drop = drop; v.lat = lat;
      v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_mis = exp_mis;
      v.exp_nbus = exp_nbus; v.exp_baddr = exp_baddr;
      v.exp_bwdata = exp_bwdata; v.exp_wstrb = exp_wstrb;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
      end
   endtask

   task automatic apply(int idx, vec_t v);
      int cyc = 0;
      int nbus = 0;
      bit got = 0;
      bit stall_ok = 1;
      bit stable = 1;
      logic [31:0] r_rdata = '0;
      logic        r_err = 1'b0, r_mis = 1'b0, b_wr = 1'b0;
      logic [31:0] b_addr = '0, b_wdata = '0;
      logic [3:0]  b_wstrb = '0;
      string       tag = $sformatf("v%0d", idx);

      @(negedge clk);
      req_valid  = 1'b1;
      req_write  = v.wr;
      req_funct3 = v.f3;
      req_addr   = v.addr;
      req_wdata  = v.wdata;
      bus_ready  = 1'b0;
      bus_rdata  = v.rdata;
      #1;
      while (!got && cyc < 60) begin
         if (cyc == v.drop) begin
            req_valid = 1'b0;
            #1;
         end
         if (stall !== (req_valid && (cyc != v.lat))) stall_ok = 0;
         if (rsp_valid) begin
            got     = 1;
            r_rdata = rsp_rdata;
            r_err   = rsp_err;
            r_mis   = misalign;
         end else begin
            if (bus_valid) begin
               nbus++;
               if (nbus == 1) begin
                  b_addr = bus_addr; b_wdata = bus_wdata;
                  b_wstrb = bus_wstrb; b_wr = bus_write;
               end else if (bus_addr !== b_addr || bus_wdata !== b_wdata ||
                            bus_wstrb !== b_wstrb || bus_write !== b_wr) begin
                  stable = 0;
               end
               bus_ready = (nbus > v.delay);
            end else begin
               bus_ready = 1'b0;
            end
            @(negedge clk);
            #1;
            cyc++;
         end
      end
      chk({tag, " rsp_seen"}, 32'(got), 32'd1);
      chk({tag, " latency"}, cyc, v.lat);
      chk({tag, " rdata"}, r_rdata, v.exp_rdata);
      chk({tag, " err"}, 32'(r_err), 32'(v.exp_err));
      chk({tag, " misalign"}, 32'(r_mis), 32'(v.exp_mis));
      chk({tag, " bus_cycles"}, nbus, v.exp_nbus);
      chk({tag, " stall"}, 32'(stall_ok), 32'd1);
      if (v.exp_nbus > 0) begin
         chk({tag, " bus_addr"}, b_addr, v.exp_baddr);
         chk({tag, " bus_wdata"}, b_wdata, v.exp_bwdata);
         chk({tag, " bus_wstrb"}, 32'(b_wstrb), 32'(v.exp_wstrb));
         chk({tag, " bus_write"}, 32'(b_wr), 32'(v.wr));
         chk({tag, " bus_stable"}, 32'(stable), 32'd1);
      end
      req_valid = 1'b0;
      bus_ready = 1'b0;
      @(negedge clk);
      #1;
      chk({tag, " rsp_pulse"}, {31'h0, rsp_valid}, 32'd0);
      chk({tag, " idle_bus"}, {31'h0, bus_valid}, 32'd0);
   endtask

   initial begin
      int rsp_seen;

      reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
      req_addr = '0; req_wdata = '0; bus_ready = 1'b0; bus_rdata = '0;

      // loads: wr f3 addr wdata rdata delay drop lat | rdata err mis nbus baddr bwdata wstrb
      vecs.push_back(mk(0, 3'b010, 32'h8,  0, 32'hDEADBEEF, 0, -1, 2, 32'hDEADBEEF, 0, 0, 1, 32'h8,  0, 4'h0));
      vecs.push_back(mk(0, 3'b000, 32'h7,  0, 32'h80FF0000, 0, -1, 2, 32'hFFFFFF80, 0, 0, 1, 32'h4,  0, 4'h0));
      vecs.push_back(mk(0, 3'b100, 32'h7,  0, 32'h80FF0000, 0, -1, 2, 32'h00000080, 0, 0, 1, 32'h4,  0, 4'h0));
      vecs.push_back(mk(0, 3'b101, 32'h6,  0, 32'h80FF0000, 0, -1, 2, 32'h000080FF, 0, 0, 1, 32'h4,  0, 4'h0));
      vecs.push_back(mk(0, 3'b001, 32'h6,  0, 32'h80FF0000, 0, -1, 2, 32'hFFFF80FF, 0, 0, 1, 32'h4,  0, 4'h0));
      vecs.push_back(mk(0, 3'b000, 32'h4,  0, 32'h1234567F, 0, -1, 2, 32'h0000007F, 0, 0, 1, 32'h4,  0, 4'h0));
      vecs.push_back(mk(0, 3'b001, 32'h0,  0, 32'h12348001, 0, -1, 2, 32'hFFFF8001, 0, 0, 1, 32'h0,  0, 4'h0));
      vecs.push_back(mk(0, 3'b100, 32'h9,  0, 32'h0000C300, 0, -1, 2, 32'h000000C3, 0, 0, 1, 32'h8,  0, 4'h0));
      vecs.push_back(mk(0, 3'b010, 32'h10, 0, 32'h01020304, 2, -1, 4, 32'h01020304, 0, 0, 3, 32'h10, 0, 4'h0));
      // stores
      vecs.push_back(mk(1, 3'b000, 32'h5, 32'h123456AB, 0, 0, -1, 2, 0, 0, 0, 1, 32'h4, 32'hABABABAB, 4'b0010));
      vecs.push_back(mk(1, 3'b001, 32'h6, 32'h0000BEEF, 0, 0, -1, 2, 0, 0, 0, 1, 32'h4, 32'hBEEFBEEF, 4'b1100));
      vecs.push_back(mk(1, 3'b001, 32'h0, 32'h99991234, 0, 0, -1, 2, 0, 0, 0, 1, 32'h0, 32'h12341234, 4'b0011));
      vecs.push_back(mk(1, 3'b010, 32'hC, 32'hCAFEF00D, 0, 3, -1, 5, 0, 0, 0, 4, 32'hC, 32'hCAFEF00D, 4'b1111));
      // illegal funct3 / unsigned stores: no bus cycle, error at cycle 1
      vecs.push_back(mk(0, 3'b011, 32'h0, 0, 32'hFFFFFFFF, 0, -1, 1, 0, 1, 0, 0, 0, 0, 4'h0));
      vecs.push_back(mk(1, 3'b100, 32'h0, 0, 32'hFFFFFFFF, 0, -1, 1, 0, 1, 0, 0, 0, 0, 4'h0));
      vecs.push_back(mk(0, 3'b110, 32'h0, 0, 32'hFFFFFFFF, 0, -1, 1, 0, 1, 0, 0, 0, 0, 4'h0));
      // timeout after 15 BUS cycles, and ready exactly on the 15th
      vecs.push_back(mk(0, 3'b010, 32'h20, 0, 32'h55555555, 100, -1, 16, 0, 1, 0, 15, 32'h20, 0, 4'h0));
      vecs.push_back(mk(0, 3'b010, 32'h24, 0, 32'hA5A5A5A5, 14, -1, 16, 32'hA5A5A5A5, 0, 0, 15, 32'h24, 0, 4'h0));
      // req_valid dropped mid-access still completes
      vecs.push_back(mk(0, 3'b010, 32'h14, 0, 32'h0BADF00D, 2, 1, 4, 32'h0BADF00D, 0, 0, 3, 32'h14, 0, 4'h0));
`ifdef LSU_MISALIGN_TRAP_EN
      vecs.push_back(mk(0, 3'b010, 32'h2, 0, 32'h11223344, 0, -1, 1, 0, 1, 1, 0, 0, 0, 4'h0));
      vecs.push_back(mk(0, 3'b001, 32'h3, 0, 32'h80000001, 0, -1, 1, 0, 1, 1, 0, 0, 0, 4'h0));
`else
      vecs.push_back(mk(0, 3'b010, 32'h2, 0, 32'h11223344, 0, -1, 2, 32'h11223344, 0, 0, 1, 32'h0, 0, 4'h0));
      vecs.push_back(mk(0, 3'b001, 32'h3, 0, 32'h80000001, 0, -1, 2, 32'hFFFF8000, 0, 0, 1, 32'h0, 0, 4'h0));
`endif

      repeat (2) @(negedge clk);
      #1;
      chk("reset outputs", {rsp_valid, bus_valid, stall, rsp_err, misalign, bus_write, bus_wstrb},
          10'h0);
      chk("reset rdata", rsp_rdata, 32'h0);
      reset = 1'b0;

      // bus_ready with no access in flight is ignored
      @(negedge clk);
      bus_ready = 1'b1;
      bus_rdata = 32'hFFFFFFFF;
      rsp_seen = 0;
      repeat (3) begin
         @(negedge clk);
         #1;
         if (rsp_valid || bus_valid) rsp_seen++;
      end
      chk("idle ready ignored", rsp_seen, 0);
      bus_ready = 1'b0;

      foreach (vecs[i]) apply(i, vecs[i]);

      // reset during BUS wait aborts the access
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010;
      req_addr = 32'h40; bus_ready = 1'b0; bus_rdata = 32'h77777777;
      repeat (4) @(negedge clk);
      #1;
      chk("abort bus_valid before reset", {31'h0, bus_valid}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      #1;
      chk("abort bus_valid after reset", {31'h0, bus_valid}, 32'd0);
      chk("abort rsp_valid after reset", {31'h0, rsp_valid}, 32'd0);
      req_valid = 1'b0;
      reset = 1'b0;
      rsp_seen = 0;
      repeat (20) begin
         @(negedge clk);
         #1;
         if (rsp_valid || bus_valid) rsp_seen++;
      end
      chk("abort no response", rsp_seen, 0);
      apply(100, mk(0, 3'b000, 32'h41, 0, 32'h0000FE00, 0, -1, 2, 32'hFFFFFFFE, 0, 0, 1, 32'h40, 0, 4'h0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
